srp_buf_ctrl: RTL

//  Sequences the 2240x8 single-port sync-sample BRAM (1-cycle read latency; dout holds while en=0).

---
 rtl/srp_buf_pkg.sv | 19 +
 rtl/srp_addr_wrap.sv | 40 ++++
 rtl/srp_buf_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/srp_buf_pkg.sv
// srp_buf_pkg
//   Shared defaults and FSM state type for the sync-sample buffer controller.
//   DEF_DEPTH      BRAM entries (addresses 0..DEPTH-1)
//   DEF_AW         address / offset width
//   DEF_DW         sample width
//   DEF_FRAME_LEN  samples streamed per trigger
package srp_buf_pkg;

    localparam int DEF_DEPTH     = 2240;
    localparam int DEF_AW        = 12;
    localparam int DEF_DW        = 8;
    localparam int DEF_FRAME_LEN = 2240;

    typedef enum logic {
        CAPTURE = 1'b0,
        READOUT = 1'b1
    } state_t;

endpackage

// File: rtl/srp_addr_wrap.sv
// srp_addr_wrap
//   Combinational modular address arithmetic for a buffer of DEPTH entries.
//   Both results stay inside 0..DEPTH-1 without relying on 2**AW wrap.
// Ports
//   base  in   AW  current address (0..DEPTH-1)
//   step  in   1   advance base by one when set
//   ofs   in   AW  distance to step back from the advanced address
//   nxt   out  AW  (base + step) mod DEPTH
//   back  out  AW  (nxt - ofs) mod DEPTH, valid for ofs <= DEPTH
module srp_addr_wrap
    import srp_buf_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic [AW-1:0] base,
    input  logic          step,
    input  logic [AW-1:0] ofs,
    output logic [AW-1:0] nxt,
    output logic [AW-1:0] back
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [AW:0] sum_raw;
    logic [AW:0] sum_mod;
    logic [AW:0] diff_raw;
    logic [AW:0] diff_mod;

    always_comb begin
        sum_raw  = {1'b0, base} + {{AW{1'b0}}, step};
        sum_mod  = (sum_raw >= DEPTH_W) ? (sum_raw - DEPTH_W) : sum_raw;
        // sum_mod < 2**AW and ofs < 2**AW, so the top bit is a true borrow flag
        diff_raw = sum_mod - {1'b0, ofs};
        diff_mod = diff_raw[AW] ? (diff_raw + DEPTH_W) : diff_raw;
        nxt      = sum_mod[AW-1:0];
        back     = diff_mod[AW-1:0];
    end

endmodule

// File: rtl/srp_buf_ctrl.sv
// srp_buf_ctrl
//   Owns the single-port sample BRAM (1-cycle read latency, dout holds while
//   en=0). Captures the ADC stream into a circular buffer; on an accepted sync
//   trigger it freezes capture, streams FRAME_LEN samples starting trig_ofs
//   entries behind the next-write address, then resumes capture.
// Ports
//   clk, rst               clock, synchronous active-high reset
//   s_data/s_valid/s_ready capture stream (s_ready high only while capturing)
//   trig, trig_ofs         sync trigger and look-back distance
//   trig_err               one-cycle pulse when a trigger is rejected
//   m_data/m_valid/m_ready readout stream, m_last marks the final sample
//   busy                   readout in progress
//   bram_en/we/addr/di     BRAM port drive
//   bram_dout              BRAM read data
//
// state   | meaning
// CAPTURE | writing samples into the circular buffer, triggers evaluated
// READOUT | capture frozen, frame streamed to the demodulator
module srp_buf_ctrl
    import srp_buf_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          trig,
    input  logic [AW-1:0] trig_ofs,
    output logic          trig_err,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy,
    output logic          bram_en,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_di,
    input  logic [DW-1:0] bram_dout
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] FRAME_W = (AW+1)'(FRAME_LEN);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    state_t        state, state_nxt;
    logic [AW-1:0] wr_ptr, wr_ptr_nxt;
    logic [AW:0]   fill, fill_nxt;
    logic [AW-1:0] rd_addr, rd_addr_nxt;
    logic [AW:0]   rd_rem, rd_rem_nxt;
    logic          m_valid_nxt;
    logic          m_last_nxt;
    logic          trig_err_nxt;

    logic          wr_fire;
    logic          rd_issue;
    logic [AW-1:0] wrap_base;
    logic          wrap_step;
    logic [AW-1:0] wrap_nxt;
    logic [AW-1:0] wrap_back;

    assign wr_fire  = (state == CAPTURE) && s_valid;
    assign rd_issue = (state == READOUT) && (rd_rem != '0) && (!m_valid || m_ready);

    // Write and read pointers never move in the same state, so one wrap unit
    // serves both. In CAPTURE, back = post-write wr_ptr minus trig_ofs.
    assign wrap_base = (state == READOUT) ? rd_addr : wr_ptr;
    assign wrap_step = (state == READOUT) ? rd_issue : wr_fire;

    srp_addr_wrap #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_wrap (
        .base (wrap_base),
        .step (wrap_step),
        .ofs  (trig_ofs),
        .nxt  (wrap_nxt),
        .back (wrap_back)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CAPTURE;
            wr_ptr   <= '0;
            fill     <= '0;
            rd_addr  <= '0;
            rd_rem   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            trig_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            fill     <= fill_nxt;
            rd_addr  <= rd_addr_nxt;
            rd_rem   <= rd_rem_nxt;
            m_valid  <= m_valid_nxt;
            m_last   <= m_last_nxt;
            trig_err <= trig_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wr_ptr_nxt   = wr_ptr;
        fill_nxt     = fill;
        rd_addr_nxt  = rd_addr;
        rd_rem_nxt   = rd_rem;
        m_valid_nxt  = m_valid;
        m_last_nxt   = m_last;
        trig_err_nxt = 1'b0;

        unique case (state)
            CAPTURE: begin
                if (wr_fire) begin
                    wr_ptr_nxt = wrap_nxt;
                    if (fill != DEPTH_W) begin
                        fill_nxt = fill + 1'b1;
                    end
                end
                // trigger sees the fill level including a same-cycle write
                if (trig) begin
                    if ((trig_ofs == '0) || ({1'b0, trig_ofs} > fill_nxt)) begin
                        trig_err_nxt = 1'b1;
                    end else begin
                        rd_addr_nxt = wrap_back;
                        rd_rem_nxt  = FRAME_W;
                        state_nxt   = READOUT;
                    end
                end
            end
            READOUT: begin
                if (rd_issue) begin
                    rd_addr_nxt = wrap_nxt;
                    rd_rem_nxt  = rd_rem - 1'b1;
                    m_valid_nxt = 1'b1;
                    m_last_nxt  = (rd_rem == ONE_W);
                end else if (m_ready) begin
                    m_valid_nxt = 1'b0;
                    m_last_nxt  = 1'b0;
                end
                // buffer history is no longer contiguous once capture resumes
                if (m_valid && m_ready && m_last) begin
                    state_nxt = CAPTURE;
                    fill_nxt  = '0;
                end
            end
            default: begin
                state_nxt = CAPTURE;
            end
        endcase
    end

    assign s_ready   = (state == CAPTURE);
    assign busy      = (state == READOUT);
    assign bram_en   = wr_fire || rd_issue;
    assign bram_we   = wr_fire;
    assign bram_addr = (state == READOUT) ? rd_addr : wr_ptr;
    assign bram_di   = s_data;
    assign m_data    = bram_dout;

endmodule
